// File: rtl/f_stage_pc_pkg.sv
// Shared constants and types for the fetch stage.
//   RESET_PC / HANDLER_PC : PC after reset / exception entry address
//   IM_BASE / IM_TOP      : inclusive legal fetch window
//   EXC_ADEL / EXC_NONE   : fetch exception codes carried into D
//   npc_sel_e             : next-PC select encoding used by the next-PC unit
//   fd_bundle_t           : contents of the F/D pipeline register
package f_stage_pc_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_TOP     = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd0;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
        logic        bd;
    } fd_bundle_t;

    // Unsigned full-width range check plus word alignment; any hit is AdEL.
    function automatic logic fetch_addr_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);
    endfunction

endpackage

// File: rtl/f_stage_pc_if.sv
// Instruction-memory fetch bus.
//   F_PC         : fetch address driven by the fetch stage
//   i_inst_rdata : instruction word returned combinationally by memory
interface f_stage_pc_if;
    logic [31:0] F_PC;
    logic [31:0] i_inst_rdata;

    modport master (output F_PC, input i_inst_rdata);
    modport slave  (input F_PC, output i_inst_rdata);
endinterface

// File: rtl/f_stage_pc_fd_reg.sv
// F/D pipeline register.
//   clk, reset : clock, async active-high reset
//   hold       : keep current contents
//   bubble     : load an empty slot tagged with bubble_pc (wins over hold)
//   bubble_pc  : PC recorded for the bubble
//   f_in       : fetch-side bundle captured on a normal edge
//   d_out      : registered decode-side bundle
module f_stage_pc_fd_reg
    import f_stage_pc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] bubble_pc,
    input  fd_bundle_t  f_in,
    output fd_bundle_t  d_out
);

    fd_bundle_t d_r;

    // F/D register: reset, bubble, hold, or capture the fetched bundle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_r <= '{pc: RESET_PC, instr: 32'h0000_0000, exc_code: EXC_NONE, bd: 1'b0};
        end else if (bubble) begin
            d_r <= '{pc: bubble_pc, instr: 32'h0000_0000, exc_code: EXC_NONE, bd: 1'b0};
        end else if (hold) begin
            d_r <= d_r;
        end else begin
            d_r <= f_in;
        end
    end

    assign d_out = d_r;

endmodule

// File: rtl/f_stage_pc.sv
// Fetch-stage PC register and F/D pipeline register.
//   clk, reset   : clock, async active-high reset
//   stall        : hazard stall, holds PC and F/D
//   req          : CP0 exception/interrupt request, redirects to HANDLER_PC
//   D_eret       : eret in D, redirects to EPC and squashes the wrong-path fetch
//   EPC          : forwarded CP0 EPC
//   npc          : next PC from the next-PC unit
//   D_is_jump    : instruction in D is a branch/jump (next D is a delay slot)
//   imem         : fetch bus (F_PC out, i_inst_rdata in)
//   D_PC, D_instr, D_ExcCode, D_BD : registered decode-stage outputs
module f_stage_pc
    import f_stage_pc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               req,
    input  logic               D_eret,
    input  logic [31:0]        EPC,
    input  logic [31:0]        npc,
    input  logic               D_is_jump,
    f_stage_pc_if.master       imem,
    output logic [31:0]        D_PC,
    output logic [31:0]        D_instr,
    output logic [4:0]         D_ExcCode,
    output logic               D_BD
);

    logic [31:0] pc_r;
    logic        f_exc_s;
    logic [31:0] f_instr_s;
    logic [4:0]  f_exc_code_s;
    logic        fd_bubble_s;
    logic [31:0] fd_bubble_pc_s;
    fd_bundle_t  f_bundle_s;
    fd_bundle_t  d_bundle_s;

    // PC register: req beats stall, and stall beats eret so a stalled eret
    // waits for EPC forwarding to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (req) begin
            pc_r <= HANDLER_PC;
        end else if (stall) begin
            pc_r <= pc_r;
        end else if (D_eret) begin
            pc_r <= EPC;
        end else begin
            pc_r <= npc;
        end
    end

    assign imem.F_PC = pc_r;

    // Fetch check: an illegal PC fetches a zero word and tags AdEL; the PC
    // itself is passed on unmasked so CP0 sees the faulting address.
    always_comb begin
        f_exc_s = fetch_addr_err(pc_r);
        if (f_exc_s) begin
            f_instr_s    = 32'h0000_0000;
            f_exc_code_s = EXC_ADEL;
        end else begin
            f_instr_s    = imem.i_inst_rdata;
            f_exc_code_s = EXC_NONE;
        end
    end

    // F/D control: bubble on req always, on eret only when not stalled.
    always_comb begin
        fd_bubble_s = req | (~stall & D_eret);
        if (req) begin
            fd_bubble_pc_s = HANDLER_PC;
        end else begin
            fd_bubble_pc_s = EPC;
        end
        f_bundle_s = '{pc: pc_r, instr: f_instr_s, exc_code: f_exc_code_s, bd: D_is_jump};
    end

    f_stage_pc_fd_reg u_fd_reg (
        .clk       (clk),
        .reset     (reset),
        .hold      (stall),
        .bubble    (fd_bubble_s),
        .bubble_pc (fd_bubble_pc_s),
        .f_in      (f_bundle_s),
        .d_out     (d_bundle_s)
    );

    assign D_PC      = d_bundle_s.pc;
    assign D_instr   = d_bundle_s.instr;
    assign D_ExcCode = d_bundle_s.exc_code;
    assign D_BD      = d_bundle_s.bd;

endmodule

// File: tb/tb_f_stage_pc.sv
// Self-checking bench for f_stage_pc: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_f_stage_pc;
    import f_stage_pc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, req, D_eret, D_is_jump;
    logic [31:0] EPC, npc;
    logic [31:0] D_PC, D_instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // behavioural model state
    logic [31:0] m_f_pc, m_d_pc, m_d_instr;
    logic [4:0]  m_d_exc;
    logic        m_d_bd;

    f_stage_pc_if imem_if ();

    f_stage_pc dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .D_eret    (D_eret),
        .EPC       (EPC),
        .npc       (npc),
        .D_is_jump (D_is_jump),
        .imem      (imem_if.master),
        .D_PC      (D_PC),
        .D_instr   (D_instr),
        .D_ExcCode (D_ExcCode),
        .D_BD      (D_BD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign imem_if.i_inst_rdata = mem_word(imem_if.F_PC);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_f_pc    = 32'h0000_3000;
        m_d_pc    = 32'h0000_3000;
        m_d_instr = 32'h0;
        m_d_exc   = 5'd0;
        m_d_bd    = 1'b0;
    endtask

    // One clock edge of the fetch stage, straight from the priority rules.
    task automatic model_edge();
        bit legal;
        legal = (m_f_pc % 4 == 0) && (m_f_pc >= 32'h0000_3000) && (m_f_pc <= 32'h0000_6FFC);
        if (req) begin
            m_f_pc = 32'h0000_4180;
            m_d_pc = 32'h0000_4180; m_d_instr = 32'h0; m_d_exc = 5'd0; m_d_bd = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (D_eret) begin
            m_d_pc = EPC; m_d_instr = 32'h0; m_d_exc = 5'd0; m_d_bd = 1'b0;
            m_f_pc = EPC;
        end else begin
            m_d_pc    = m_f_pc;
            m_d_instr = legal ? mem_word(m_f_pc) : 32'h0;
            m_d_exc   = legal ? 5'd0 : 5'd4;
            m_d_bd    = D_is_jump;
            m_f_pc    = npc;
        end
    endtask

    always @(posedge reset) model_reset();

    // Compare process: advance the model each edge, then check shortly after.
    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_edge();
        #1;
        if (chk_en) begin
            check("F_PC",      imem_if.F_PC, m_f_pc);
            check("D_PC",      D_PC,         m_d_pc);
            check("D_instr",   D_instr,      m_d_instr);
            check("D_ExcCode", {27'd0, D_ExcCode}, {27'd0, m_d_exc});
            check("D_BD",      {31'd0, D_BD},      {31'd0, m_d_bd});
        end
    end

    // Drive one cycle's inputs on the falling edge and wait past the next rise.
    task automatic step(input logic s, input logic r, input logic e,
                        input logic [31:0] epc_v, input logic [31:0] npc_v, input logic j);
        @(negedge clk);
        stall = s; req = r; D_eret = e; EPC = epc_v; npc = npc_v; D_is_jump = j;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_addr(input logic [31:0] cur);
        logic [31:0] edges [6];
        edges[0] = 32'h0000_2FFC; edges[1] = 32'h0000_3000; edges[2] = 32'h0000_6FFC;
        edges[3] = 32'h0000_7000; edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h0000_0000;
        case ($urandom_range(0, 4))
            0:       return 32'h0000_3000 + 32'($urandom_range(0, 4095)) * 32'd4;
            1:       return edges[$urandom_range(0, 5)];
            2:       return 32'h0000_3000 + 32'($urandom_range(0, 16383)) | 32'd1;
            3:       return $urandom;
            default: return cur + 32'd4;
        endcase
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0; D_eret = 1'b0;
        EPC = 32'h0; npc = 32'h0000_3000; D_is_jump = 1'b0;
        #12;
        chk_en = 1'b1;
        check("rst_F_PC",  imem_if.F_PC, 32'h0000_3000);
        check("rst_D_PC",  D_PC,         32'h0000_3000);
        check("rst_D_instr", D_instr,    32'h0);
        @(negedge clk); reset = 1'b0;

        // sequential fetch
        check("seq_F0", imem_if.F_PC, 32'h0000_3000);
        step(1'b0, 1'b0, 1'b0, 32'h0, m_f_pc + 32'd4, 1'b0);
        check("seq_F1", imem_if.F_PC, 32'h0000_3004);
        check("seq_D1", D_PC, 32'h0000_3000);
        check("seq_I1", D_instr, mem_word(32'h0000_3000));
        step(1'b0, 1'b0, 1'b0, 32'h0, m_f_pc + 32'd4, 1'b0);
        check("seq_F2", imem_if.F_PC, 32'h0000_3008);
        check("seq_D2", D_PC, 32'h0000_3004);
        step(1'b0, 1'b0, 1'b0, 32'h0, m_f_pc + 32'd4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, m_f_pc + 32'd4, 1'b0);
        check("seq_F4", imem_if.F_PC, 32'h0000_3010);

        // stall for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_5550, 1'b1);
            check("stall_F", imem_if.F_PC, 32'h0000_3010);
            check("stall_D", D_PC, 32'h0000_300C);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3040, 1'b0);
        check("unstall_F", imem_if.F_PC, 32'h0000_3040);

        // misaligned then out-of-range fetch
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3002, 1'b0);
        check("mis_F", imem_if.F_PC, 32'h0000_3002);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_7000, 1'b0);
        check("mis_D_PC",  D_PC, 32'h0000_3002);
        check("mis_exc",   {27'd0, D_ExcCode}, 32'd4);
        check("mis_instr", D_instr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
        check("oor_D_PC",  D_PC, 32'h0000_7000);
        check("oor_exc",   {27'd0, D_ExcCode}, 32'd4);

        // req overrides stall and eret
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3100, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_3AA0, 32'h0000_3200, 1'b1);
        check("req_F",  imem_if.F_PC, 32'h0000_4180);
        check("req_D",  D_PC, 32'h0000_4180);
        check("req_I",  D_instr, 32'h0);
        check("req_BD", {31'd0, D_BD}, 32'd0);

        // eret unstalled, then eret held by stall
        step(1'b0, 1'b0, 1'b1, 32'h0000_3020, 32'h0000_3300, 1'b0);
        check("eret_F", imem_if.F_PC, 32'h0000_3020);
        check("eret_D", D_PC, 32'h0000_3020);
        check("eret_I", D_instr, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h0000_3050, 32'h0000_3300, 1'b0);
            check("eret_stall_F", imem_if.F_PC, 32'h0000_3020);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0000_3050, 32'h0000_3300, 1'b0);
        check("eret_rel_F", imem_if.F_PC, 32'h0000_3050);

        // delay slot flag
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3054, 1'b1);
        check("bd_D", {31'd0, D_BD}, 32'd1);
        check("bd_D_PC", D_PC, 32'h0000_3050);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), rand_addr(m_f_pc),
                 rand_addr(m_f_pc), ($urandom_range(0, 3) == 0));
        end

        // async reset mid-cycle
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_F",  imem_if.F_PC, 32'h0000_3000);
        check("arst_D",  D_PC, 32'h0000_3000);
        check("arst_I",  D_instr, 32'h0);
        check("arst_E",  {27'd0, D_ExcCode}, 32'd0);
        check("arst_BD", {31'd0, D_BD}, 32'd0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), rand_addr(m_f_pc),
                 rand_addr(m_f_pc), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
